// File: rtl/mod_pingpong_ctrl.sv
// Ping-pong symbol buffer controller between the modulation mapper and the
// transform-precoding stage. Mapper writes go to bank wb. A completed bank is
// frozen and read out to the consumer over a valid/ready handshake.
//
// Read FSM states:
//   state   | meaning
//   RD_IDLE | no block being read; waits for bank rb to become FULL
//   RD_READ | presenting Rd_addr/Rd_sel of bank rb; advances on Rd_ready
//
// Bank states:
//   state        | meaning
//   BANK_EMPTY   | nothing written since the last drain or reset
//   BANK_FILLING | at least one symbol written, block not yet complete
//   BANK_FULL    | block complete, frozen until read out
module mod_pingpong_ctrl #(
    parameter int ADDR_WIDTH  = 11,
    parameter int MAX_SYMBOLS = 1200
) (
    input  logic                  CLK_PP,
    input  logic                  RST_PP,
    input  logic                  Wr_valid,
    input  logic [ADDR_WIDTH-1:0] Wr_addr_in,
    input  logic                  Wr_done,
    input  logic [ADDR_WIDTH-1:0] Last_addr_in,
    input  logic                  Rd_ready,
    output logic                  Bank_wr_en0,
    output logic                  Bank_wr_en1,
    output logic [ADDR_WIDTH-1:0] Bank_wr_addr,
    output logic                  Rd_sel,
    output logic [ADDR_WIDTH-1:0] Rd_addr,
    output logic                  Rd_valid,
    output logic                  Rd_last,
    output logic                  Blk_start,
    output logic [ADDR_WIDTH-1:0] Blk_len,
    output logic                  Stall,
    output logic                  Overflow
);

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_t;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_READ = 1'b1
    } rd_state_t;

    localparam logic [ADDR_WIDTH-1:0] MAX_SYM = ADDR_WIDTH'(MAX_SYMBOLS);
    localparam logic [ADDR_WIDTH-1:0] ONE     = ADDR_WIDTH'(1);

    bank_state_t           bank_q [2];
    bank_state_t           bank_d [2];
    logic [ADDR_WIDTH-1:0] len_q  [2];
    logic [ADDR_WIDTH-1:0] len_d  [2];
    logic                  wb_q, wb_d;
    logic                  rb_q, rb_d;
    logic                  wb_other;
    rd_state_t             rd_st_q, rd_st_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  rd_sel_q, rd_sel_d;
    logic [ADDR_WIDTH-1:0] blk_len_q, blk_len_d;
    logic                  blk_start_q, blk_start_d;
    logic                  stall_q, stall_d;
    logic                  ovf_q, ovf_d;

    logic                  addr_ok;
    logic                  len_ok;
    logic                  wb_full;
    logic                  wr_ok;
    logic                  wr_bad;
    logic                  done_ok;
    logic                  done_bad;
    logic                  rd_active;
    logic                  rd_last_c;
    logic                  rd_xfer;
    logic                  drain;

    assign wb_other = ~wb_q;

    // Write-side qualification; a Wr_done on an already frozen bank would
    // overwrite the length of a block still waiting to be read, so it is
    // treated like a write into a full bank.
    always_comb begin
        addr_ok  = (Wr_addr_in != '0) && (Wr_addr_in <= MAX_SYM);
        len_ok   = (Last_addr_in != '0) && (Last_addr_in <= MAX_SYM);
        wb_full  = (bank_q[wb_q] == BANK_FULL);
        wr_ok    = Wr_valid & addr_ok & ~wb_full;
        wr_bad   = Wr_valid & ~wr_ok;
        done_ok  = Wr_done & len_ok & ~wb_full;
        done_bad = Wr_done & ~done_ok;
    end

    assign rd_active = (rd_st_q == RD_READ);
    assign rd_last_c = rd_active & (rd_addr_q == (blk_len_q - ONE));
    assign rd_xfer   = rd_active & Rd_ready;
    assign drain     = rd_xfer & rd_last_c;

    // Bank state, lengths, write pointer, Stall and Overflow next values.
    // wb moves whenever its bank is frozen and the other one is free, which
    // covers both a completion into a free pair and a drain that unblocks.
    always_comb begin
        bank_d = bank_q;
        len_d  = len_q;
        wb_d   = wb_q;
        if (wr_ok && (bank_q[wb_q] == BANK_EMPTY)) begin
            bank_d[wb_q] = BANK_FILLING;
        end
        if (done_ok) begin
            bank_d[wb_q] = BANK_FULL;
            len_d[wb_q]  = Last_addr_in;
        end
        if (drain) begin
            bank_d[rb_q] = BANK_EMPTY;
        end
        if ((bank_d[wb_q] == BANK_FULL) && (bank_d[wb_other] == BANK_EMPTY)) begin
            wb_d = wb_other;
        end
        stall_d = (bank_d[wb_d] == BANK_FULL);
        ovf_d   = ovf_q | wr_bad | done_bad;
    end

    // Read FSM next state and read-side registers.
    always_comb begin
        rd_st_d     = rd_st_q;
        rb_d        = rb_q;
        rd_addr_d   = rd_addr_q;
        rd_sel_d    = rd_sel_q;
        blk_len_d   = blk_len_q;
        blk_start_d = 1'b0;
        case (rd_st_q)
            RD_IDLE: begin
                if (bank_q[rb_q] == BANK_FULL) begin
                    rd_st_d     = RD_READ;
                    rd_addr_d   = '0;
                    rd_sel_d    = rb_q;
                    blk_len_d   = len_q[rb_q];
                    blk_start_d = 1'b1;
                end
            end
            RD_READ: begin
                if (rd_xfer) begin
                    if (rd_last_c) begin
                        rd_st_d   = RD_IDLE;
                        rb_d      = ~rb_q;
                        rd_addr_d = '0;
                    end else begin
                        rd_addr_d = rd_addr_q + ONE;
                    end
                end
            end
            default: rd_st_d = RD_IDLE;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge CLK_PP) begin
        if (!RST_PP) begin
            bank_q[0]   <= BANK_EMPTY;
            bank_q[1]   <= BANK_EMPTY;
            len_q[0]    <= '0;
            len_q[1]    <= '0;
            wb_q        <= 1'b0;
            rb_q        <= 1'b0;
            rd_st_q     <= RD_IDLE;
            rd_addr_q   <= '0;
            rd_sel_q    <= 1'b0;
            blk_len_q   <= '0;
            blk_start_q <= 1'b0;
            stall_q     <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            bank_q      <= bank_d;
            len_q       <= len_d;
            wb_q        <= wb_d;
            rb_q        <= rb_d;
            rd_st_q     <= rd_st_d;
            rd_addr_q   <= rd_addr_d;
            rd_sel_q    <= rd_sel_d;
            blk_len_q   <= blk_len_d;
            blk_start_q <= blk_start_d;
            stall_q     <= stall_d;
            ovf_q       <= ovf_d;
        end
    end

    assign Bank_wr_en0  = wr_ok & ~wb_q;
    assign Bank_wr_en1  = wr_ok & wb_q;
    assign Bank_wr_addr = wr_ok ? (Wr_addr_in - ONE) : '0;
    assign Rd_sel       = rd_sel_q;
    assign Rd_addr      = rd_addr_q;
    assign Rd_valid     = rd_active;
    assign Rd_last      = rd_last_c;
    assign Blk_start    = blk_start_q;
    assign Blk_len      = blk_len_q;
    assign Stall        = stall_q;
    assign Overflow     = ovf_q;

endmodule

// File: tb/tb_mod_pingpong_ctrl.sv
// Bench for mod_pingpong_ctrl: per-cycle vector table for single-block and
// simultaneous-completion timing, then hand-written multi-cycle sequences.
module tb_mod_pingpong_ctrl;

    logic        CLK_PP = 1'b0;
    logic        RST_PP = 1'b0;
    logic        Wr_valid = 1'b0;
    logic [10:0] Wr_addr_in = '0;
    logic        Wr_done = 1'b0;
    logic [10:0] Last_addr_in = '0;
    logic        Rd_ready = 1'b0;
    logic        Bank_wr_en0, Bank_wr_en1;
    logic [10:0] Bank_wr_addr;
    logic        Rd_sel;
    logic [10:0] Rd_addr;
    logic        Rd_valid, Rd_last, Blk_start;
    logic [10:0] Blk_len;
    logic        Stall, Overflow;

    int n_tests = 0;
    int n_fail  = 0;

    mod_pingpong_ctrl #(.ADDR_WIDTH(11), .MAX_SYMBOLS(1200)) dut (
        .CLK_PP(CLK_PP), .RST_PP(RST_PP),
        .Wr_valid(Wr_valid), .Wr_addr_in(Wr_addr_in), .Wr_done(Wr_done),
        .Last_addr_in(Last_addr_in), .Rd_ready(Rd_ready),
        .Bank_wr_en0(Bank_wr_en0), .Bank_wr_en1(Bank_wr_en1), .Bank_wr_addr(Bank_wr_addr),
        .Rd_sel(Rd_sel), .Rd_addr(Rd_addr), .Rd_valid(Rd_valid), .Rd_last(Rd_last),
        .Blk_start(Blk_start), .Blk_len(Blk_len), .Stall(Stall), .Overflow(Overflow)
    );

    always #5 CLK_PP = ~CLK_PP;

    typedef struct packed {
        logic        en0;
        logic        en1;
        logic [10:0] wad;
        logic        sel;
        logic [10:0] ra;
        logic        rv;
        logic        rl;
        logic        bs;
        logic [10:0] bl;
        logic        st;
        logic        ov;
    } out_t;

    typedef struct packed {
        logic        rst;
        logic        chk;
        logic        wv;
        logic [10:0] wa;
        logic        wd;
        logic [10:0] la;
        logic        rr;
        out_t        want;
    } vec_t;

    typedef struct packed {
        logic        sel;
        logic [10:0] addr;
        logic        last;
        logic        start;
        logic [10:0] len;
    } xfer_t;

    vec_t  vecs[$];
    xfer_t mon_q[$];
    logic  mon_en = 1'b0;

    // Transfer monitor, sampled mid-low-phase after inputs have settled.
    always @(negedge CLK_PP) begin
        #2;
        if (mon_en && Rd_valid && Rd_ready)
            mon_q.push_back({Rd_sel, Rd_addr, Rd_last, Blk_start, Blk_len});
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic out_t o(input logic en0, input logic en1, input int wad,
                               input logic sel, input int ra, input logic rv,
                               input logic rl, input logic bs, input int bl,
                               input logic st, input logic ov);
        out_t r;
        r.en0 = en0; r.en1 = en1; r.wad = 11'(wad); r.sel = sel; r.ra = 11'(ra);
        r.rv = rv; r.rl = rl; r.bs = bs; r.bl = 11'(bl); r.st = st; r.ov = ov;
        return r;
    endfunction

    function automatic out_t cur_out();
        return {Bank_wr_en0, Bank_wr_en1, Bank_wr_addr, Rd_sel, Rd_addr, Rd_valid,
                Rd_last, Blk_start, Blk_len, Stall, Overflow};
    endfunction

    task automatic add(input logic rst, input logic chk, input logic wv, input int wa,
                       input logic wd, input int la, input logic rr, input out_t w);
        vec_t v;
        v.rst = rst; v.chk = chk; v.wv = wv; v.wa = 11'(wa); v.wd = wd;
        v.la = 11'(la); v.rr = rr; v.want = w;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic cyc(input logic wv, input int wa, input logic wd, input int la, input logic rr);
        @(negedge CLK_PP);
        Wr_valid = wv; Wr_addr_in = 11'(wa); Wr_done = wd; Last_addr_in = 11'(la); Rd_ready = rr;
        #1;
    endtask

    task automatic do_reset();
        @(negedge CLK_PP);
        RST_PP = 1'b0;
        Wr_valid = 1'b0; Wr_addr_in = '0; Wr_done = 1'b0; Last_addr_in = '0; Rd_ready = 1'b0;
        @(negedge CLK_PP);
        RST_PP = 1'b1;
        #1;
    endtask

    initial begin
        out_t z;
        int   errs;
        int   bad;
        int   stall_seen;
        int   hold_cnt;
        logic found;
        logic p_rv, p_rr, p_rl, p_sel;
        logic [10:0] p_ra;
        xfer_t e;

        z = '0;
        // ---- single block, then illegal write addresses ----
        add(1,0,0,0,0,0,0, z);
        add(0,1,0,0,0,0,1, z);
        add(0,1,1,1,0,0,1, o(1,0,0, 0,0,0,0,0,0, 0,0));
        add(0,1,1,2,0,0,1, o(1,0,1, 0,0,0,0,0,0, 0,0));
        add(0,1,1,3,0,0,1, o(1,0,2, 0,0,0,0,0,0, 0,0));
        add(0,1,1,4,0,0,1, o(1,0,3, 0,0,0,0,0,0, 0,0));
        add(0,1,0,0,1,4,1, z);
        add(0,1,0,0,0,0,1, z);
        add(0,1,0,0,0,0,1, o(0,0,0, 0,0,1,0,1,4, 0,0));
        add(0,1,0,0,0,0,1, o(0,0,0, 0,1,1,0,0,4, 0,0));
        add(0,1,0,0,0,0,1, o(0,0,0, 0,2,1,0,0,4, 0,0));
        add(0,1,0,0,0,0,1, o(0,0,0, 0,3,1,1,0,4, 0,0));
        add(0,1,1,1,0,0,1, o(0,1,0, 0,0,0,0,0,4, 0,0));
        add(0,1,1,0,0,0,1, o(0,0,0, 0,0,0,0,0,4, 0,0));
        add(0,1,0,0,0,0,1, o(0,0,0, 0,0,0,0,0,4, 0,1));
        add(0,1,1,1201,0,0,1, o(0,0,0, 0,0,0,0,0,4, 0,1));
        add(0,1,1,1200,0,0,1, o(0,1,1199, 0,0,0,0,0,4, 0,1));
        add(0,1,0,0,0,0,1, o(0,0,0, 0,0,0,0,0,4, 0,1));
        // ---- Wr_done to bank 1 in the same cycle as bank 0's last read ----
        add(1,0,0,0,0,0,0, z);
        add(0,1,1,1,0,0,1, o(1,0,0, 0,0,0,0,0,0, 0,0));
        add(0,1,1,2,0,0,1, o(1,0,1, 0,0,0,0,0,0, 0,0));
        add(0,1,1,3,0,0,1, o(1,0,2, 0,0,0,0,0,0, 0,0));
        add(0,1,1,4,0,0,1, o(1,0,3, 0,0,0,0,0,0, 0,0));
        add(0,1,0,0,1,4,1, z);
        add(0,1,1,1,0,0,1, o(0,1,0, 0,0,0,0,0,0, 0,0));
        add(0,1,1,2,0,0,1, o(0,1,1, 0,0,1,0,1,4, 0,0));
        add(0,1,1,3,0,0,1, o(0,1,2, 0,1,1,0,0,4, 0,0));
        add(0,1,1,4,0,0,1, o(0,1,3, 0,2,1,0,0,4, 0,0));
        add(0,1,0,0,1,4,1, o(0,0,0, 0,3,1,1,0,4, 0,0));
        add(0,1,1,1,0,0,1, o(1,0,0, 0,0,0,0,0,4, 0,0));
        add(0,1,0,0,0,0,1, o(0,0,0, 1,0,1,0,1,4, 0,0));
        add(0,1,0,0,0,0,1, o(0,0,0, 1,1,1,0,0,4, 0,0));
        add(0,1,0,0,0,0,1, o(0,0,0, 1,2,1,0,0,4, 0,0));
        add(0,1,0,0,0,0,1, o(0,0,0, 1,3,1,1,0,4, 0,0));
        add(0,1,0,0,0,0,1, o(0,0,0, 1,0,0,0,0,4, 0,0));

        foreach (vecs[i]) begin
            @(negedge CLK_PP);
            RST_PP = ~vecs[i].rst;
            Wr_valid = vecs[i].wv; Wr_addr_in = vecs[i].wa; Wr_done = vecs[i].wd;
            Last_addr_in = vecs[i].la; Rd_ready = vecs[i].rr;
            #1;
            if (vecs[i].chk) check($sformatf("vec%0d", i), 64'(cur_out()), 64'(vecs[i].want));
        end

        // ---- back-to-back blocks: 1200 into bank 0, 600 into bank 1 ----
        do_reset();
        mon_q.delete();
        mon_en = 1'b1;
        errs = 0; stall_seen = 0;
        for (int i = 1; i <= 1200; i++) begin
            cyc(1, i, 0, 0, 1);
            if (!(Bank_wr_en0 && !Bank_wr_en1 && Bank_wr_addr == 11'(i - 1))) errs++;
            if (Stall) stall_seen++;
        end
        cyc(0, 0, 1, 1200, 1);
        for (int i = 1; i <= 600; i++) begin
            cyc(1, i, 0, 0, 1);
            if (!(Bank_wr_en1 && !Bank_wr_en0 && Bank_wr_addr == 11'(i - 1))) errs++;
            if (Stall) stall_seen++;
        end
        cyc(0, 0, 1, 600, 1);
        for (int n = 0; n < 3000 && mon_q.size() < 1800; n++) cyc(0, 0, 0, 0, 1);
        check("b2b_write_errors", errs, 0);
        check("b2b_stall_during_writes", stall_seen, 0);
        check("b2b_xfer_count", mon_q.size(), 1800);
        bad = 0;
        foreach (mon_q[k]) begin
            if (k < 1200) e = {1'b0, 11'(k), k == 1199, k == 0, 11'd1200};
            else          e = {1'b1, 11'(k - 1200), k == 1799, k == 1200, 11'd600};
            if (mon_q[k] !== e) bad++;
        end
        check("b2b_order_mismatches", bad, 0);
        check("b2b_overflow", Overflow, 0);
        mon_en = 1'b0;

        // ---- both banks full with Rd_ready low ----
        do_reset();
        errs = 0;
        for (int i = 1; i <= 8; i++) cyc(1, i, 0, 0, 0);
        cyc(0, 0, 1, 8, 0);
        for (int i = 1; i <= 8; i++) begin
            cyc(1, i, 0, 0, 0);
            if (!Bank_wr_en1 || Bank_wr_en0) errs++;
        end
        check("full_second_block_bank1", errs, 0);
        cyc(0, 0, 1, 8, 0);
        cyc(1, 1, 0, 0, 0);
        check("full_stall", Stall, 1);
        check("full_write_dropped", {Bank_wr_en0, Bank_wr_en1}, 2'b00);
        check("full_read_held", {Rd_valid, Rd_sel, Rd_addr}, {1'b1, 1'b0, 11'd0});
        cyc(0, 0, 0, 0, 0);
        check("full_overflow", Overflow, 1);
        errs = 0;
        for (int k = 0; k < 8; k++) begin
            cyc(0, 0, 0, 0, 1);
            if (!(Stall && Rd_valid && Rd_addr == 11'(k) && !Rd_sel)) errs++;
        end
        check("full_drain_sequence", errs, 0);
        check("full_drain_last", Rd_last, 1);
        cyc(0, 0, 0, 0, 1);
        check("full_stall_drop", {Stall, Rd_valid}, 2'b00);
        cyc(0, 0, 0, 0, 1);
        check("full_bank1_start", {Rd_valid, Rd_sel, Blk_start, Blk_len}, {3'b111, 11'd8});
        check("overflow_sticky", Overflow, 1);

        // ---- backpressure: Rd_ready toggles every cycle ----
        do_reset();
        mon_q.delete();
        mon_en = 1'b1;
        for (int i = 1; i <= 5; i++) cyc(1, i, 0, 0, 0);
        cyc(0, 0, 1, 5, 0);
        errs = 0; hold_cnt = 0;
        p_rv = 1'b0; p_rr = 1'b0; p_rl = 1'b0; p_sel = 1'b0; p_ra = '0;
        for (int n = 0; n < 40; n++) begin
            cyc(0, 0, 0, 0, (n % 2) == 0);
            if (p_rv && !p_rr) begin
                hold_cnt++;
                if (!(Rd_valid && Rd_addr == p_ra && Rd_sel == p_sel)) errs++;
            end else if (p_rv && p_rr && !p_rl) begin
                if (!(Rd_valid && Rd_addr == p_ra + 11'd1)) errs++;
            end
            p_rv = Rd_valid; p_rr = Rd_ready; p_ra = Rd_addr; p_sel = Rd_sel; p_rl = Rd_last;
        end
        mon_en = 1'b0;
        check("bp_step_errors", errs, 0);
        check("bp_hold_seen", hold_cnt > 0, 1);
        check("bp_xfer_count", mon_q.size(), 5);
        bad = 0;
        foreach (mon_q[k])
            if (!(mon_q[k].sel == 1'b0 && mon_q[k].addr == 11'(k) &&
                  mon_q[k].last == (k == 4) && mon_q[k].len == 11'd5)) bad++;
        check("bp_order_mismatches", bad, 0);

        // ---- reset mid-read ----
        do_reset();
        cyc(1, 0, 0, 0, 1);
        for (int i = 1; i <= 5; i++) cyc(1, i, 0, 0, 1);
        cyc(0, 0, 1, 5, 1);
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            cyc(0, 0, 0, 0, 1);
            if (Rd_valid && Rd_addr == 11'd3) found = 1'b1;
        end
        check("rst_reached_addr3", found, 1);
        check("rst_overflow_before", Overflow, 1);
        RST_PP = 1'b0;
        Rd_ready = 1'b0;
        @(negedge CLK_PP);
        #1;
        check("rst_all_outputs_zero", 64'(cur_out()), 64'(z));
        RST_PP = 1'b1;
        errs = 0;
        for (int n = 0; n < 4; n++) begin
            cyc(0, 0, 0, 0, 1);
            if (Rd_valid || Stall || Overflow) errs++;
        end
        check("rst_banks_empty", errs, 0);
        cyc(1, 1, 0, 0, 1);
        check("rst_wb_is_0", {Bank_wr_en0, Bank_wr_en1, Bank_wr_addr}, {2'b10, 11'd0});

        // ---- illegal block lengths, then a 1-symbol block ----
        do_reset();
        cyc(0, 0, 1, 1201, 1);
        cyc(0, 0, 0, 0, 1);
        check("done_len1201_overflow", Overflow, 1);
        do_reset();
        cyc(0, 0, 1, 0, 1);
        cyc(0, 0, 0, 0, 1);
        check("done_len0_overflow", Overflow, 1);
        errs = 0;
        for (int n = 0; n < 3; n++) begin
            cyc(0, 0, 0, 0, 1);
            if (Rd_valid) errs++;
        end
        check("done_illegal_no_read", errs, 0);
        cyc(1, 1, 1, 1, 1);
        check("len1_write", {Bank_wr_en0, Bank_wr_en1, Bank_wr_addr}, {2'b10, 11'd0});
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        check("len1_read", 64'(cur_out()), 64'(o(0,0,0, 0,0,1,1,1,1, 0,1)));
        cyc(0, 0, 0, 0, 1);
        check("len1_done", Rd_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
